fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle core. It issues word fetches to instruction memory over a req/ack handshake, which tolerates variable memory latency. Fetched words and their byte-address PCs are buffered in a small prefetch FIFO. The FIFO is flushed and refetch is redirected whenever the core takes a jump (target = pc + 4 + sext(imm16)) or halts.

---
 rtl/fetch_unit.sv | 209 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: req/ack word fetches into a prefetch FIFO with jump/halt redirect.
// Optional build macro FETCH_PERF_EN adds the fetch_cnt / kill_cnt performance counters.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        busy
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] fetch_cnt,
    output logic [15:0] kill_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    w_fetch_pc_next;
    logic           r_mem_req;
    logic           w_mem_req_next;
    logic [31:0]    r_mem_addr;
    logic [31:0]    w_mem_addr_next;

    logic [31:0]    r_fifo_pc   [DEPTH];
    logic [31:0]    r_fifo_inst [DEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_next;

    logic [31:0]    w_redirect_pc;
    logic [31:0]    w_base_pc;
    logic           w_push;
    logic           w_pop;
    logic           w_can_issue;
    logic           w_issue;
    logic [1:0]     w_unused_pc_lsb;

    assign w_unused_pc_lsb = redirect_pc[1:0];
    assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
    // A redirect takes effect on the same edge, so any issue this cycle uses the new target.
    assign w_base_pc       = redirect ? w_redirect_pc : r_fetch_pc;

    assign w_push = mem_ack && (r_state == S_WAIT) && !redirect;
    assign w_pop  = (r_count != {CW{1'b0}}) && inst_ready && !redirect;

    assign w_count_next = redirect ? {CW{1'b0}}
                                   : (r_count + CW'(w_push) - CW'(w_pop));
    assign w_can_issue  = !halt && (w_count_next < CW'(DEPTH));

    // FSM next-state, request and fetch-pc update.
    always_comb begin
        w_state_next    = r_state;
        w_mem_req_next  = r_mem_req;
        w_mem_addr_next = r_mem_addr;
        w_fetch_pc_next = w_base_pc;
        w_issue         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_issue) begin
                    w_issue = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    if (w_can_issue) begin
                        w_issue = 1'b1;
                    end else begin
                        w_mem_req_next = 1'b0;
                        w_state_next   = S_IDLE;
                    end
                end else if (redirect) begin
                    w_state_next = S_KILL;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_KILL: begin
                if (mem_ack) begin
                    if (w_can_issue) begin
                        w_issue = 1'b1;
                    end else begin
                        w_mem_req_next = 1'b0;
                        w_state_next   = S_IDLE;
                    end
                end else begin
                    w_state_next = S_KILL;
                end
            end
            default: begin
                w_mem_req_next = 1'b0;
                w_state_next   = S_IDLE;
            end
        endcase
        if (w_issue) begin
            w_mem_req_next  = 1'b1;
            w_mem_addr_next = w_base_pc;
            w_fetch_pc_next = w_base_pc + 32'd4;
            w_state_next    = S_WAIT;
        end else begin
            w_fetch_pc_next = w_base_pc;
        end
    end

    // FSM state, memory request and fetch-pc registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
            r_fetch_pc <= w_fetch_pc_next;
        end
    end

    // Prefetch FIFO storage, pointers and occupancy; a redirect empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_fifo_pc[i]   <= 32'h0000_0000;
                r_fifo_inst[i] <= 32'h0000_0000;
            end
        end else if (redirect) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]   <= r_mem_addr;
                r_fifo_inst[r_wr_ptr] <= mem_rdata;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_next;
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign busy       = (r_state != S_IDLE);
    assign inst_valid = (r_count != {CW{1'b0}});
    assign inst       = r_fifo_inst[r_rd_ptr];
    assign inst_pc    = r_fifo_pc[r_rd_ptr];

`ifdef FETCH_PERF_EN
    logic        w_discard;
    logic [15:0] w_kill_inc;
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_kill_cnt;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Killed responses plus every entry thrown away by a flush.
    assign w_discard  = mem_ack && ((r_state == S_KILL) || ((r_state == S_WAIT) && redirect));
    assign w_kill_inc = (redirect ? 16'(r_count) : 16'h0000) + 16'(w_discard);

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= 16'h0000;
            r_kill_cnt  <= 16'h0000;
        end else begin
            r_fetch_cnt <= sat_add(r_fetch_cnt, 16'(w_push));
            r_kill_cnt  <= sat_add(r_kill_cnt, w_kill_inc);
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign kill_cnt  = r_kill_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a redirect vector table and an
// in-order scoreboard of {pc, inst} expected at the FIFO head.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        busy;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] kill_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] model_pc;
    logic        kill_pend;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } redir_vec_t;
    redir_vec_t vecs[4];

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .busy       (busy)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .kill_cnt   (kill_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_1234;
    endfunction

    assign mem_rdata = word_at(mem_addr);

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    // Scoreboard: compare pops, enqueue kept responses, track redirects and kills.
    task automatic monitor();
        exp_t e;
        if (rst) begin
            exp_q.delete();
            model_pc  = 32'h0000_0000;
            kill_pend = 1'b0;
        end else begin
            if (inst_valid && inst_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_pop: actual pc=%h required no valid head", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk32("sb_pc", inst_pc, e.pc);
                    chk32("sb_inst", inst, e.word);
                end
            end
            if (mem_req && mem_ack) begin
                if (!redirect && !kill_pend) begin
                    exp_q.push_back('{pc: model_pc, word: word_at(model_pc)});
                    model_pc = model_pc + 32'd4;
                end
                kill_pend = 1'b0;
            end
            if (redirect) begin
                exp_q.delete();
                model_pc = {redirect_pc[31:2], 2'b00};
                if (mem_req && !mem_ack) kill_pend = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{rpc: 32'h0000_0103, exp_addr: 32'h0000_0100, exp_next: 32'h0000_0104};
        vecs[1] = '{rpc: 32'h0000_0040, exp_addr: 32'h0000_0040, exp_next: 32'h0000_0044};
        vecs[2] = '{rpc: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
        vecs[3] = '{rpc: 32'h0000_2001, exp_addr: 32'h0000_2000, exp_next: 32'h0000_2004};

        rst = 1'b1; mem_ack = 1'b1; inst_ready = 1'b1; redirect = 1'b0;
        redirect_pc = 32'h0; halt = 1'b0;
        model_pc = 32'h0; kill_pend = 1'b0;
        cyc(); cyc();

        chk1 ("rst_mem_req", mem_req, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0000_0000);
        chk1 ("rst_inst_valid", inst_valid, 1'b0);
        chk32("rst_inst", inst, 32'h0000_0000);
        chk32("rst_inst_pc", inst_pc, 32'h0000_0000);
        chk1 ("rst_busy", busy, 1'b0);

        // Streaming: ack always, consumer always ready.
        rst = 1'b0;
        cyc();
        chk1 ("first_req", mem_req, 1'b1);
        chk32("first_addr", mem_addr, 32'h0000_0000);
        chk1 ("first_busy", busy, 1'b1);
        chk1 ("first_no_valid", inst_valid, 1'b0);
        cyc();
        chk1 ("stream_valid0", inst_valid, 1'b1);
        chk32("stream_pc0", inst_pc, 32'h0000_0000);
        chk32("stream_inst0", inst, word_at(32'h0000_0000));
        chk32("stream_addr1", mem_addr, 32'h0000_0004);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk32("stream_addr", mem_addr, 32'd8 + 32'(i) * 32'd4);
            chk1 ("stream_valid", inst_valid, 1'b1);
        end

        // FIFO fills with the consumer stalled.
        rst = 1'b1; #1;
        cyc();
        inst_ready = 1'b0; rst = 1'b0;
        repeat (5) cyc();
        chk1 ("full_req_low", mem_req, 1'b0);
        chk1 ("full_busy", busy, 1'b0);
        chk1 ("full_valid", inst_valid, 1'b1);
        chk32("full_head_pc", inst_pc, 32'h0000_0000);
        cyc(); cyc();
        chk1 ("full_req_stays_low", mem_req, 1'b0);
        inst_ready = 1'b1;
        cyc();
        chk1 ("full_reissue_req", mem_req, 1'b1);
        chk32("full_reissue_addr", mem_addr, 32'h0000_0010);
        chk32("full_head_after_pop", inst_pc, 32'h0000_0004);
        inst_ready = 1'b0;
        cyc();
        chk1 ("full_again_req_low", mem_req, 1'b0);
        inst_ready = 1'b1;
        repeat (6) cyc();

        // Redirect table: redirect coincides with an ack while streaming.
        for (int v = 0; v < 4; v++) begin
            redirect = 1'b1; redirect_pc = vecs[v].rpc;
            cyc();
            redirect = 1'b0;
            chk1 ("redir_valid_low", inst_valid, 1'b0);
            chk1 ("redir_req", mem_req, 1'b1);
            chk32("redir_addr", mem_addr, vecs[v].exp_addr);
            cyc();
            chk1 ("redir_first_valid", inst_valid, 1'b1);
            chk32("redir_first_pc", inst_pc, vecs[v].exp_addr);
            chk32("redir_first_inst", inst, word_at(vecs[v].exp_addr));
            chk32("redir_next_addr", mem_addr, vecs[v].exp_next);
            cyc(); cyc();
        end

        // Delayed ack with a redirect in the second wait cycle.
        rst = 1'b1; mem_ack = 1'b0; #1;
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        chk1 ("kill_w1_req", mem_req, 1'b1);
        chk32("kill_w1_addr", mem_addr, 32'h0000_0000);
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        cyc();
        redirect = 1'b0;
        chk1 ("kill_hold_req", mem_req, 1'b1);
        chk32("kill_hold_addr", mem_addr, 32'h0000_0000);
        chk1 ("kill_busy", busy, 1'b1);
        chk1 ("kill_no_valid", inst_valid, 1'b0);
        mem_ack = 1'b1;
        cyc();
        chk32("kill_next_addr", mem_addr, 32'h0000_0040);
        chk1 ("kill_not_pushed", inst_valid, 1'b0);
        cyc();
        chk1 ("kill_target_valid", inst_valid, 1'b1);
        chk32("kill_target_pc", inst_pc, 32'h0000_0040);
        chk32("kill_target_inst", inst, word_at(32'h0000_0040));

        // Halt while a request is outstanding.
        rst = 1'b1; mem_ack = 1'b0; #1;
        cyc();
        rst = 1'b0;
        cyc();
        halt = 1'b1;
        cyc();
        chk1 ("halt_wait_req", mem_req, 1'b1);
        chk1 ("halt_wait_busy", busy, 1'b1);
        mem_ack = 1'b1;
        cyc();
        chk1 ("halt_req_low", mem_req, 1'b0);
        chk1 ("halt_busy_low", busy, 1'b0);
        chk1 ("halt_pushed_valid", inst_valid, 1'b1);
        chk32("halt_pushed_pc", inst_pc, 32'h0000_0000);
        cyc();
        chk1 ("halt_no_new_req", mem_req, 1'b0);
        chk1 ("halt_drained", inst_valid, 1'b0);
        halt = 1'b0;
        cyc();
        chk1 ("resume_req", mem_req, 1'b1);
        chk32("resume_addr", mem_addr, 32'h0000_0004);
        cyc();
        chk1 ("resume_valid", inst_valid, 1'b1);
        chk32("resume_pc", inst_pc, 32'h0000_0004);
        cyc(); cyc();

        // Asynchronous reset while a request is outstanding.
        chk1 ("pre_rst_req", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1 ("async_rst_req", mem_req, 1'b0);
        chk32("async_rst_addr", mem_addr, 32'h0000_0000);
        chk1 ("async_rst_busy", busy, 1'b0);
        chk1 ("async_rst_valid", inst_valid, 1'b0);
        cyc();
        chk1 ("late_ack_ignored", mem_req, 1'b0);
        rst = 1'b0;
        cyc();
        chk1 ("restart_req", mem_req, 1'b1);
        chk32("restart_addr", mem_addr, 32'h0000_0000);
        cyc();
        chk1 ("restart_valid", inst_valid, 1'b1);
        chk32("restart_pc", inst_pc, 32'h0000_0000);
        chk32("restart_inst", inst, word_at(32'h0000_0000));
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
